// File: rtl/svf_ctrl_if.sv
// Register write bus for the SVF control block.
// The master drives the write strobe, address and data. The slave receives them.
interface svf_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/svf_ctrl.sv
// State-variable filter sequencer: generates the sample strobe, slews the cutoff coefficient,
// sequences filter flush/reset, and mixes the HP/BP/LP taps into one saturated registered sample.
module svf_ctrl #(
  parameter int unsigned CLK_DIV      = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  svf_ctrl_if.slave    bus,
  input  logic [7:0]   audio_in,
  input  logic [7:0]   filt_hp,
  input  logic [7:0]   filt_bp,
  input  logic [7:0]   filt_lp,
  output logic [7:0]   svf_audio_in,
  output logic         sample_valid,
  output logic [10:0]  alpha1,
  output logic [1:0]   alpha2,
  output logic         svf_rst,
  output logic [7:0]   audio_out,
  output logic         running
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned FlW  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [FlW-1:0]  fcnt_q, fcnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      target_q, slew_q, scnt_q, scnt_d, cur_fc_q, cur_fc_d;
  logic [5:0]      cfg_q;
  logic [1:0]      alpha2_q;
  logic [7:0]      audio_out_q, mix;
  logic            svf_rst_q, running_q;
  logic            ctrl_wr, slew_wr;
  logic [8:0]      scnt_inc;
  logic signed [9:0] sum;

  assign ctrl_wr = bus.wr_en && (bus.wr_addr == 2'd3);
  assign slew_wr = bus.wr_en && (bus.wr_addr == 2'd2);

  assign sample_valid = (state_q == StRun) && (div_q == DivW'(CLK_DIV - 1));
  assign svf_audio_in = audio_in;
  assign alpha1       = {cur_fc_q, 3'b000};
  assign alpha2       = alpha2_q;
  assign svf_rst      = svf_rst_q;
  assign audio_out    = audio_out_q;
  assign running      = running_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = '0;
    case (state_q)
      StIdle: begin
        if (ctrl_wr && bus.wr_data[0]) state_d = bus.wr_data[1] ? StFlush : StRun;
      end
      StRun: begin
        if (ctrl_wr) begin
          if (!bus.wr_data[0])     state_d = StIdle;
          else if (bus.wr_data[1]) state_d = StFlush;
        end
      end
      StFlush: begin
        if (ctrl_wr && !bus.wr_data[0]) begin
          state_d = StIdle;
        end else if (ctrl_wr && bus.wr_data[1]) begin
          fcnt_d = '0;  // re-flush restarts the hold count
        end else if (fcnt_q == FlW'(FLUSH_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          fcnt_d = fcnt_q + FlW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Divider runs only while staying in RUN, so entry always starts a full period.
  always_comb begin
    div_d = '0;
    if (state_q == StRun && state_d == StRun) begin
      div_d = (div_q == DivW'(CLK_DIV - 1)) ? '0 : div_q + DivW'(1);
    end
  end

  always_comb begin
    scnt_inc = {1'b0, scnt_q} + 9'd1;
    scnt_d   = scnt_q;
    cur_fc_d = cur_fc_q;
    if (sample_valid) begin
      if (slew_q == 8'd0) begin
        cur_fc_d = target_q;
      end else if (scnt_inc == {1'b0, slew_q}) begin
        scnt_d = 8'd0;
        if (cur_fc_q < target_q)      cur_fc_d = cur_fc_q + 8'd1;
        else if (cur_fc_q > target_q) cur_fc_d = cur_fc_q - 8'd1;
      end else begin
        scnt_d = scnt_inc[7:0];
      end
    end
    if (slew_wr || state_d != StRun) scnt_d = 8'd0;
  end

  always_comb begin
    sum = 10'sd0;
    if (cfg_q[0]) sum = sum + {{2{filt_lp[7]}}, filt_lp};
    if (cfg_q[1]) sum = sum + {{2{filt_bp[7]}}, filt_bp};
    if (cfg_q[2]) sum = sum + {{2{filt_hp[7]}}, filt_hp};
    if (cfg_q[5])               mix = audio_in;
    else if (sum > 10'sd127)    mix = 8'h7F;
    else if (sum < -10'sd128)   mix = 8'h80;
    else                        mix = sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      fcnt_q      <= '0;
      div_q       <= '0;
      target_q    <= 8'd0;
      cfg_q       <= 6'd0;
      slew_q      <= 8'd0;
      scnt_q      <= 8'd0;
      cur_fc_q    <= 8'd0;
      alpha2_q    <= 2'd0;
      audio_out_q <= 8'd0;
      svf_rst_q   <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      div_q     <= div_d;
      scnt_q    <= scnt_d;
      cur_fc_q  <= cur_fc_d;
      svf_rst_q <= (state_d != StRun);
      running_q <= (state_d == StRun);
      if (bus.wr_en) begin
        case (bus.wr_addr)
          2'd0:    target_q <= bus.wr_data;
          2'd1:    cfg_q    <= bus.wr_data[5:0];
          2'd2:    slew_q   <= bus.wr_data;
          default: ;
        endcase
      end
      if (sample_valid) begin
        alpha2_q    <= cfg_q[4:3];
        audio_out_q <= mix;
      end
    end
  end

endmodule

// File: tb/tb_svf_ctrl.sv
// Directed bench for svf_ctrl with CLK_DIV=32 and FLUSH_CYCLES=2.
// It checks the tick timing, cutoff slewing, mixing, flush sequencing and asynchronous reset.
module tb_svf_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  svf_ctrl_if bus ();
  logic [7:0]  audio_in = 8'd0, filt_hp = 8'd0, filt_bp = 8'd0, filt_lp = 8'd0;
  logic [7:0]  svf_audio_in, audio_out;
  logic        sample_valid, svf_rst, running;
  logic [10:0] alpha1;
  logic [1:0]  alpha2;

  int n_total = 0;
  int n_pass  = 0;

  svf_ctrl #(.CLK_DIV(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .audio_in(audio_in), .filt_hp(filt_hp),
    .filt_bp(filt_bp), .filt_lp(filt_lp), .svf_audio_in(svf_audio_in),
    .sample_valid(sample_valid), .alpha1(alpha1), .alpha2(alpha2), .svf_rst(svf_rst),
    .audio_out(audio_out), .running(running)
  );

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Returns at the negedge inside the next sample_valid cycle.
  task automatic wait_tick();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL tick_timeout: got no sample_valid in 200 cycles, required one");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    @(negedge clk); @(negedge clk);
    n_total++;
    if ({sample_valid, alpha1, alpha2, svf_rst, audio_out, running} !== {1'b0, 11'd0, 2'd0,
        1'b1, 8'd0, 1'b0}) $display("FAIL reset_values: sv=%b a1=%h a2=%h srst=%b out=%h run=%b",
        sample_valid, alpha1, alpha2, svf_rst, audio_out, running);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sample_valid || running || !svf_rst) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL idle_quiet: %0d bad cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_run_ticks();
    int bad_idx = -1;
    wr(2'd3, 8'h01);
    n_total++;
    if ({svf_rst, running} !== 2'b01) $display("FAIL run_entry: srst/run=%b required 01",
        {svf_rst, running});
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) @(negedge clk);
      if (bad_idx < 0 && sample_valid !== (i == 31 || i == 63)) bad_idx = i;
    end
    n_total++;
    if (bad_idx !== -1) $display("FAIL tick_period: first wrong cycle %0d, required none",
        bad_idx);
    else n_pass++;
  endtask

  task automatic test_cutoff_immediate();
    @(negedge clk);
    wr(2'd0, 8'h40);
    n_total++;
    if (alpha1 !== 11'h000) $display("FAIL alpha1_pre: %h required 000", alpha1); else n_pass++;
    wait_tick();
    n_total++;
    if (alpha1 !== 11'h000) $display("FAIL alpha1_stable: %h required 000", alpha1);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (alpha1 !== 11'h200) $display("FAIL alpha1_imm: %h required 200", alpha1); else n_pass++;
  endtask

  task automatic test_slew();
    logic [10:0] e;
    wr(2'd0, 8'h00);
    wait_tick(); @(negedge clk);
    n_total++;
    if (alpha1 !== 11'h000) $display("FAIL alpha1_zero: %h required 000", alpha1); else n_pass++;
    wr(2'd2, 8'd2);
    wr(2'd0, 8'h10);
    for (int k = 1; k <= 24; k++) begin
      wait_tick(); @(negedge clk);
      e = 11'(k / 2) << 3;
      n_total++;
      if (alpha1 !== e) $display("FAIL slew_up[%0d]: %h required %h", k, alpha1, e);
      else n_pass++;
    end
    wr(2'd0, 8'h08);
    for (int j = 1; j <= 12; j++) begin
      wait_tick(); @(negedge clk);
      e = 11'((12 - j / 2) < 8 ? 8 : (12 - j / 2)) << 3;
      n_total++;
      if (alpha1 !== e) $display("FAIL slew_down[%0d]: %h required %h", j, alpha1, e);
      else n_pass++;
    end
    wr(2'd0, 8'h10);
    for (int m = 1; m <= 20; m++) begin
      wait_tick(); @(negedge clk);
      e = 11'((8 + m / 2) > 16 ? 16 : (8 + m / 2)) << 3;
      n_total++;
      if (alpha1 !== e) $display("FAIL slew_hold[%0d]: %h required %h", m, alpha1, e);
      else n_pass++;
    end
  endtask

  task automatic test_mix();
    filt_lp = 8'd100; filt_bp = 8'd60; filt_hp = 8'hF6;
    wr(2'd1, 8'h17);
    n_total++;
    if ({alpha2, audio_out} !== {2'd0, 8'h00}) $display("FAIL mix_pre: a2=%h out=%h required 0 00",
        alpha2, audio_out);
    else n_pass++;
    wait_tick();
    n_total++;
    if (alpha2 !== 2'd0) $display("FAIL alpha2_stable: %h required 0", alpha2); else n_pass++;
    @(negedge clk);
    n_total++;
    if ({alpha2, audio_out} !== {2'd2, 8'h7F}) $display("FAIL mix_sat_hi: a2=%h out=%h required 2 7f",
        alpha2, audio_out);
    else n_pass++;
    filt_lp = 8'h9C; filt_bp = 8'h9C; filt_hp = 8'h9C;
    wait_tick(); @(negedge clk);
    n_total++;
    if (audio_out !== 8'h80) $display("FAIL mix_sat_lo: %h required 80", audio_out); else n_pass++;
    filt_bp = 8'd5;
    repeat (5) @(negedge clk);
    n_total++;
    if (audio_out !== 8'h80) $display("FAIL mix_hold: %h required 80", audio_out); else n_pass++;
    wr(2'd1, 8'h01);
    wait_tick(); @(negedge clk);
    n_total++;
    if ({alpha2, audio_out} !== {2'd0, 8'h9C}) $display("FAIL mix_lp: a2=%h out=%h required 0 9c",
        alpha2, audio_out);
    else n_pass++;
    filt_bp = 8'd60; filt_hp = 8'hF6;
    wr(2'd1, 8'h06);
    wait_tick(); @(negedge clk);
    n_total++;
    if (audio_out !== 8'h32) $display("FAIL mix_bp_hp: %h required 32", audio_out); else n_pass++;
    wr(2'd1, 8'h00);
    wait_tick(); @(negedge clk);
    n_total++;
    if (audio_out !== 8'h00) $display("FAIL mix_none: %h required 00", audio_out); else n_pass++;
    audio_in = 8'hFB;
    wr(2'd1, 8'h20);
    wait_tick(); @(negedge clk);
    n_total++;
    if ({audio_out, svf_audio_in} !== {8'hFB, 8'hFB})
      $display("FAIL mix_bypass: out=%h pass=%h required fb fb", audio_out, svf_audio_in);
    else n_pass++;
  endtask

  task automatic test_flush();
    int bad_idx = -1;
    wr(2'd3, 8'h03);
    n_total++;
    if ({svf_rst, running, sample_valid} !== 3'b100)
      $display("FAIL flush_c0: srst/run/sv=%b required 100", {svf_rst, running, sample_valid});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({svf_rst, running, sample_valid} !== 3'b100)
      $display("FAIL flush_c1: srst/run/sv=%b required 100", {svf_rst, running, sample_valid});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({svf_rst, running} !== 2'b01) $display("FAIL flush_exit: srst/run=%b required 01",
        {svf_rst, running});
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      if (bad_idx < 0 && sample_valid !== (i == 31)) bad_idx = i;
    end
    n_total++;
    if (bad_idx !== -1) $display("FAIL flush_tick: first wrong cycle %0d, required none", bad_idx);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk);
    wr(2'd2, 8'd1);
    wr(2'd0, 8'hF0);
    repeat (3) wait_tick();
    @(negedge clk);
    n_total++;
    if ({audio_out, alpha1} !== {8'hFB, 11'h098})
      $display("FAIL pre_reset: out=%h a1=%h required fb 098", audio_out, alpha1);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({sample_valid, alpha1, alpha2, svf_rst, audio_out, running} !== {1'b0, 11'd0, 2'd0,
        1'b1, 8'd0, 1'b0}) $display("FAIL async_reset: sv=%b a1=%h a2=%h srst=%b out=%h run=%b",
        sample_valid, alpha1, alpha2, svf_rst, audio_out, running);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sample_valid || running || !svf_rst) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL post_reset_idle: %0d bad cycles, required 0", bad); else n_pass++;
    wr(2'd3, 8'h01);
    wait_tick(); @(negedge clk);
    n_total++;
    if ({alpha1, audio_out} !== {11'd0, 8'd0})
      $display("FAIL regs_cleared: a1=%h out=%h required 000 00", alpha1, audio_out);
    else n_pass++;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 8'd0;
    test_reset();
    test_run_ticks();
    test_cutoff_immediate();
    test_slew();
    test_mix();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/svf_ctrl.md
# svf_ctrl

Sequencer and configuration front-end for the 8-bit state-variable filter in the audio path. It generates the filter's sample strobe from the system clock and slews the cutoff coefficient toward a programmed target. It drives the damping and filter-reset controls and mixes the filter's HP/BP/LP outputs into one registered 8-bit sample. It sits between the register bus and the filter datapath; the filter instance itself is external.

## Interface
- CLK_DIV, 32: clocks per sample tick; legal 2..1024.
- FLUSH_CYCLES, 2: cycles `svf_rst` is held during a flush; legal ≥1.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- wr_en  in  1  register write strobe; one write per cycle; always accepted.
- wr_addr  in  2  register select.
- wr_data  in  8  write data.
- audio_in  in  8  signed dry sample.
- filt_hp, filt_bp, filt_lp  in  8 each  signed filter outputs (combinational from the filter).
- svf_audio_in  out  8  signed filter input; equals `audio_in`, combinational.
- sample_valid  out  1  one-cycle filter update strobe.
- alpha1  out  11  cutoff coefficient = {cur_fc, 3'b000}.
- alpha2  out  2  damping coefficient.
- svf_rst  out  1  synchronous clear to the filter state.
- audio_out  out  8  signed mixed output, registered.
- running  out  1  high in the RUN state.

## Operation
- Registers (all reset to 0):
  - addr0 TARGET[7:0]: cutoff target.
  - addr1 CFG: [0] lp_en, [1] bp_en, [2] hp_en, [4:3] alpha2, [5] bypass.
  - addr2 SLEW[7:0]: sample ticks per cutoff step; 0 = immediate.
  - addr3 CTRL: [0] run, [1] flush. Flush is a self-clearing pulse and is not stored.
- A write to an address lands on the clock edge where `wr_en` is sampled high. The new value is visible from the next cycle.
- States:
  - IDLE: the reset state.
    - A CTRL write with run=1 and flush=0 → RUN.
    - A CTRL write with run=1 and flush=1 → FLUSH.
  - RUN:
    - A CTRL write with run=0 → IDLE; flush is ignored.
    - A CTRL write with run=1 and flush=1 → FLUSH.
  - FLUSH:
    - Counts FLUSH_CYCLES cycles, then → RUN.
    - A CTRL write with run=0 during FLUSH → IDLE immediately.
    - A CTRL write with flush=1 during FLUSH restarts the count.
- `svf_rst` = registered (next_state != RUN). It is 1 in IDLE and FLUSH and 0 in RUN.
- Divider:
  - 0..CLK_DIV-1, counting only in RUN.
  - Cleared to 0 on entry to RUN.
  - Held at 0 outside RUN.
  - `sample_valid` = 1 for exactly the cycle in which div == CLK_DIV-1 in RUN.
  - The first tick occurs CLK_DIV cycles after entering RUN.
- Cutoff slew (cur_fc, 8-bit unsigned):
  - Updates only on the edge ending a `sample_valid` cycle.
  - If SLEW=0: cur_fc ← TARGET.
  - Otherwise a slew counter increments each tick. When it reaches SLEW, the counter clears and cur_fc steps by ±1 toward TARGET.
  - cur_fc does not step if cur_fc == TARGET.
  - Retargeting mid-ramp redirects the ramp from the current cur_fc; it never jumps.
  - The slew counter clears on a SLEW write and on leaving RUN.
  - cur_fc holds its value in IDLE and FLUSH.
- `alpha2` = CFG[4:3]; changes take effect only at the next `sample_valid` edge (registered on tick). Reset value 0.
- Mix:
  - Computed on `sample_valid` cycles only.
  - Sum = 10-bit signed sum of the enabled filt_lp, filt_bp and filt_hp, sign-extended.
  - Saturate the sum to −128..127.
  - bypass=1 selects `audio_in` instead of the sum.
  - No outputs enabled and bypass=0 gives 0.
  - The result is registered into `audio_out` on the tick edge.
  - `audio_out` holds between ticks and in IDLE/FLUSH.

## Timing
- Reset values: sample_valid=0, alpha1=0, alpha2=0, svf_rst=1, audio_out=0, running=0. All registers are 0, state is IDLE, all counters are 0.
- Reset assertion mid-operation clears everything asynchronously. No tick may be emitted in the cycle reset deasserts.
- Tick period is exactly CLK_DIV cycles in steady RUN. No tick is emitted during FLUSH, and no partial period follows a flush.
- `alpha1` and `alpha2` are stable during every `sample_valid` cycle. They change only on the edge that ends that cycle.
- `audio_out` latency: 1 cycle after the `sample_valid` cycle. It captures the filter outputs present during the tick cycle.
- `running` and `svf_rst` change on the edge after the state transition.

## Test plan
- Reset, then write CTRL=0x01 → `svf_rst` falls the next cycle; the first `sample_valid` comes CLK_DIV cycles later; pulses are 1 cycle wide, every 32 cycles.
- TARGET=0x40 and SLEW=0 while running → `alpha1`=0x200 the cycle after the next tick.
- TARGET=0x10 and SLEW=2 from cur_fc=0 → cur_fc increments every 2nd tick. After 32 ticks cur_fc=0x10, then it holds. Retarget to 0x08 at cur_fc=0x0C → it ramps down from 0x0C.
- CFG=0x07 with filt_lp=100, filt_bp=60, filt_hp=−10 → `audio_out`=127 (saturated). With filt_lp=filt_bp=filt_hp=−100 → −128. With bypass=1 and audio_in=−5 → −5.
- Write CTRL=0x03 while running → `svf_rst`=1 for 2 cycles, no ticks during the flush; the next tick comes CLK_DIV cycles after returning to RUN.
- Assert rst mid-ramp with audio_out≠0 → all outputs return to their reset values immediately. After release, IDLE with no ticks until run is written.
